// File: rtl/piso_tx_arbiter.sv
// Round-robin front end for one shared PISO shift register: grants a word from
// one of two requesters, holds it, and sequences load/shift with zero-gap streaming.
module piso_tx_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt1,
  output logic [WIDTH-1:0] piso_d,
  output logic             s,
  output logic             bit_valid,
  output logic             src,
  output logic             done,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LAST} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold;
  logic             ptr;
  logic             win;
  logic             pend;
  logic             src_r;
  logic             window;
  logic             pick1;
  logic             grant;

  // Handshake: a requester keeps reqN high with dN stable until it sees gntN
  // high in a cycle; that cycle is the transfer. Next cycle it drops reqN or
  // presents a fresh word. gnt only rises while the grant window is open.
  always_comb begin
    window = !rst && ((state == IDLE) || ((state == SHIFT) && (cnt == CNT_LAST)));
    pick1  = req1 && (!req0 || ptr);
    grant  = window && (req0 || req1);
    gnt0   = grant && !pick1;
    gnt1   = grant && pick1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (grant) state_nx = LOAD;
      LOAD:  state_nx = SHIFT;
      SHIFT: if (cnt == CNT_LAST) state_nx = LAST;
      LAST:  state_nx = pend ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
      ptr   <= 1'b0;
      win   <= 1'b0;
      pend  <= 1'b0;
      src_r <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state == SHIFT) ? cnt + CW'(1) : '0;
      // pend remembers a grant taken in the final SHIFT cycle so LAST can
      // chain straight into the next word.
      pend  <= grant && (state == SHIFT);
      if (grant) begin
        hold <= pick1 ? d1 : d0;
        ptr  <= ~pick1;
        win  <= pick1;
      end
      if ((state_nx == SHIFT) && (state != SHIFT)) src_r <= win;
    end
  end

  always_comb begin
    piso_d    = hold;
    s         = (state == SHIFT);
    bit_valid = (state == SHIFT) || (state == LAST);
    done      = (state == LAST);
    busy      = (state != IDLE);
    src       = src_r;
    dbg_state = state;
  end

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Bench for piso_tx_arbiter: WIDTH=4 and WIDTH=2 instances, each feeding a
// behavioural shift register whose serial bits are scoreboarded.
module tb_piso_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=4 instance
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] d0 = '0, d1 = '0;
  logic       gnt0, gnt1, s, bit_valid, src, done, busy;
  logic [3:0] piso_d;
  logic [1:0] dbg4;

  piso_tx_arbiter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .req0(req0), .d0(d0), .gnt0(gnt0), .req1(req1), .d1(d1),
    .gnt1(gnt1), .piso_d(piso_d), .s(s), .bit_valid(bit_valid), .src(src),
    .done(done), .busy(busy), .dbg_state(dbg4)
  );

  // WIDTH=2 instance
  logic       r2_req0 = 1'b0;
  logic       r2_req1 = 1'b0;
  logic [1:0] r2_d0 = '0;
  logic [1:0] r2_d1 = '0;
  logic       gnt0_2, gnt1_2, s2, bv2, src2, done2, busy2;
  logic [1:0] piso_d2;
  logic [1:0] dbg2;

  piso_tx_arbiter #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .req0(r2_req0), .d0(r2_d0), .gnt0(gnt0_2), .req1(r2_req1),
    .d1(r2_d1), .gnt1(gnt1_2), .piso_d(piso_d2), .s(s2), .bit_valid(bv2), .src(src2),
    .done(done2), .busy(busy2), .dbg_state(dbg2)
  );

  // Behavioural shift registers: load piso_d when s=0, shift left when s=1.
  logic [3:0] sr4;
  logic [1:0] sr2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sr4 <= '0;
      sr2 <= '0;
    end else begin
      sr4 <= s  ? {sr4[2:0], 1'b0} : piso_d;
      sr2 <= s2 ? {sr2[0], 1'b0}   : piso_d2;
    end
  end

  // Scoreboard entries: {src, done, q}
  logic [2:0] exp_q4[$];
  logic [2:0] exp_q2[$];
  int rise4 = 0, rise2 = 0;
  logic prev_bv4 = 1'b0, prev_bv2 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push4(input logic sid, input logic [3:0] w);
    for (int i = 3; i >= 0; i--) exp_q4.push_back({sid, (i == 0), w[i]});
  endtask

  task automatic push2(input logic sid, input logic [1:0] w);
    for (int i = 1; i >= 0; i--) exp_q2.push_back({sid, (i == 0), w[i]});
  endtask

  // Monitors: pop and compare whenever a payload bit (or a done) is presented.
  always @(negedge clk) begin
    logic [2:0] e;
    if (bit_valid || done) begin
      if (exp_q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bit4_unexpected: got %0h with empty queue at %0t", {src, done, sr4[3]}, $time);
      end else begin
        e = exp_q4.pop_front();
        chk("bit4", 32'({src, done, sr4[3]}), 32'(e));
      end
    end
    if (bit_valid && !prev_bv4) rise4++;
    prev_bv4 = bit_valid;
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (bv2 || done2) begin
      if (exp_q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bit2_unexpected: got %0h with empty queue at %0t", {src2, done2, sr2[1]}, $time);
      end else begin
        e = exp_q2.pop_front();
        chk("bit2", 32'({src2, done2, sr2[1]}), 32'(e));
      end
    end
    if (bv2 && !prev_bv2) rise2++;
    prev_bv2 = bv2;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_piso_d"}, 32'(piso_d), 32'(0));
    chk({nm, "_s"}, 32'(s), 32'(0));
    chk({nm, "_bv"}, 32'(bit_valid), 32'(0));
    chk({nm, "_src"}, 32'(src), 32'(0));
    chk({nm, "_done"}, 32'(done), 32'(0));
    chk({nm, "_busy"}, 32'(busy), 32'(0));
    chk({nm, "_gnt"}, 32'({gnt1, gnt0}), 32'(0));
    chk({nm, "_state"}, 32'(dbg4), 32'(0));
  endtask

  // Wait up to max_wait extra cycles for a grant on dut4; check identity and
  // that it arrived in time, then queue the expected word. Returns after the edge.
  task automatic grant4(input string nm, input logic exp_id, input logic [3:0] w,
                        input int max_wait);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!(gnt0 || gnt1) && waited < max_wait) begin
      tick();
      waited++;
      @(negedge clk);
    end
    if (gnt0 || gnt1) begin
      chk({nm, "_id"}, 32'(gnt1), 32'(exp_id));
      chk({nm, "_onehot"}, 32'(gnt0 && gnt1), 32'(0));
      push4(exp_id, w);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no grant within %0d cycles", nm, max_wait);
    end
    tick();
  endtask

  task automatic wait_idle4(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      tick();
      n++;
      @(negedge clk);
    end
    chk({nm, "_idle"}, 32'(busy), 32'(0));
    tick();
  endtask

  initial begin
    logic s_seq[6];
    int r0;
    int waited;
    logic [1:0] w2;
    s_seq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b0;

    // Single word 1011 from requester 0, s sequence from the grant cycle
    req0 = 1'b1;
    d0   = 4'b1011;
    r0   = rise4;
    @(negedge clk);
    chk("t1_gnt0", 32'(gnt0), 32'(1));
    chk("t1_gnt1", 32'(gnt1), 32'(0));
    chk("t1_s0", 32'(s), 32'(s_seq[0]));
    push4(1'b0, 4'b1011);
    tick();
    req0 = 1'b0;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      chk("t1_s_seq", 32'(s), 32'(s_seq[i]));
      tick();
    end
    @(negedge clk);
    chk("t1_busy_after", 32'(busy), 32'(0));
    tick();

    // Both requesters held from reset: grants alternate, no gap
    rst  = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    d0   = 4'b1100;
    d1   = 4'b0011;
    @(negedge clk);
    chk("t2_gnt_in_reset", 32'({gnt1, gnt0}), 32'(0));
    chk("t2_busy_in_reset", 32'(busy), 32'(0));
    tick();
    rst = 1'b0;
    r0  = rise4;
    grant4("t2_g0", 1'b0, 4'b1100, 0);
    grant4("t2_g1", 1'b1, 4'b0011, 6);
    grant4("t2_g2", 1'b0, 4'b1100, 6);
    grant4("t2_g3", 1'b1, 4'b0011, 6);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle4("t2");
    chk("t2_continuous", 32'(rise4 - r0), 32'(1));

    // req1 arrives in the second SHIFT cycle; granted only at cnt == 2
    r0   = rise4;
    req0 = 1'b1;
    d0   = 4'b1010;
    grant4("t3_g0", 1'b0, 4'b1010, 0);
    req0 = 1'b0;
    tick();
    tick();
    req1 = 1'b1;
    d1   = 4'b0101;
    @(negedge clk);
    chk("t3_no_gnt1_early", 32'(gnt1), 32'(0));
    tick();
    grant4("t3_g1", 1'b1, 4'b0101, 0);
    req1 = 1'b0;
    wait_idle4("t3");
    chk("t3_continuous", 32'(rise4 - r0), 32'(1));

    // Asynchronous reset mid-SHIFT drops the word
    req0 = 1'b1;
    d0   = 4'b1111;
    grant4("t4_g0", 1'b0, 4'b1111, 0);
    req0 = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t4_midreset");
    exp_q4.delete();
    @(posedge clk);
    #1;
    rst  = 1'b0;
    req1 = 1'b1;
    d1   = 4'b0110;
    grant4("t4_g1", 1'b1, 4'b0110, 0);
    req1 = 1'b0;
    wait_idle4("t4");
    @(negedge clk);
    chk("t4_src_held", 32'(src), 32'(1));
    tick();

    // Window closed in LOAD and LAST
    r0   = rise4;
    req0 = 1'b1;
    d0   = 4'b1001;
    grant4("t6_g0", 1'b0, 4'b1001, 0);
    d0 = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_closed_a", 32'(gnt0), 32'(0));
      tick();
    end
    grant4("t6_g1", 1'b0, 4'b0111, 0);
    d0 = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_closed_b", 32'(gnt0), 32'(0));
      tick();
    end
    grant4("t6_g2", 1'b0, 4'b1110, 0);
    req0 = 1'b0;
    wait_idle4("t6");
    chk("t6_continuous", 32'(rise4 - r0), 32'(1));

    // WIDTH=2: req0 held, words alternate 10 / 01, a grant every SHIFT cycle
    r0      = rise2;
    r2_req0 = 1'b1;
    w2      = 2'b10;
    r2_d0   = w2;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      @(negedge clk);
      while (!gnt0_2 && waited < 8) begin
        tick();
        waited++;
        @(negedge clk);
      end
      chk("t5_gnt", 32'(gnt0_2), 32'(1));
      chk("t5_spacing", 32'(waited), 32'((k == 0) ? 0 : 1));
      if (gnt0_2) push2(1'b0, w2);
      tick();
      w2    = ~w2;
      r2_d0 = w2;
    end
    r2_req0 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t5_idle", 32'(busy2), 32'(0));
    chk("t5_continuous", 32'(rise2 - r0), 32'(1));

    chk("q4_drained", 32'(exp_q4.size()), 32'(0));
    chk("q2_drained", 32'(exp_q2.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piso_tx_arbiter.md
Name: piso_tx_arbiter

Overview:
- Controller that shares one WIDTH-bit parallel-in/serial-out shift register between two requesters.
- Arbitrates round-robin between the requesters and captures the winner's word into a holding register.
- Drives the shift register's parallel input (piso_d) and its mode line (s: 0 = load, 1 = shift, MSB first).
- Flags when the serial output bit is valid, and sequences back-to-back words with no idle gap.

Parameters:
- WIDTH, 4, word width of the shift register; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req0  input  1  requester 0 has a word; d0 is held stable while req0 is high.
- d0  input  WIDTH  requester 0 word.
- gnt0  output  1  combinational; word d0 accepted this cycle.
- req1  input  1  requester 1 has a word.
- d1  input  WIDTH  requester 1 word.
- gnt1  output  1  combinational; word d1 accepted this cycle.
- piso_d  output  WIDTH  parallel data to the shift register (the holding register).
- s  output  1  shift-register mode: 0 = load on the next edge, 1 = shift on the next edge.
- bit_valid  output  1  the shift register's serial output q carries a payload bit this cycle.
- src  output  1  requester that owns the word currently being serialised.
- done  output  1  one-cycle pulse during the last bit of a word.
- busy  output  1  the state is not IDLE.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, hold = 0, ptr = 0 (requester 0 has priority), cnt = 0.
  - Outputs at reset: piso_d = 0, s = 0, bit_valid = 0, src = 0, done = 0, busy = 0, gnt0 = gnt1 = 0.
  - Reset mid-word drops the word silently; no done pulse is issued.
- The state machine has four states: IDLE, LOAD, SHIFT, LAST.
  - IDLE: s = 0. Grant window is open. On a grant, go to LOAD; otherwise stay in IDLE.
  - LOAD: s = 0 (the shift register captures piso_d on this edge). Set cnt = 0 and go to SHIFT.
  - SHIFT: s = 1, bit_valid = 1. Increment cnt each cycle. When cnt == WIDTH-2, go to LAST.
  - LAST: s = 0, bit_valid = 1, done = 1.
    - The edge leaving LAST loads the shift register with hold.
    - If a grant occurred in the final SHIFT cycle, go to SHIFT with cnt = 0 and src updated (zero-gap streaming).
    - Otherwise go to IDLE; the stale load is harmless because bit_valid is 0.
- Grant window: open when state == IDLE, or when state == SHIFT and cnt == WIDTH-2. It is closed in every other state.
- Arbitration inside the window:
  - Only one requester high: it wins.
  - Both high: the requester pointed to by ptr wins.
  - The winner's gnt is high for exactly one cycle. hold <= winner's d and ptr <= ~winner at that edge.
  - Winner identity is registered and becomes src when its word enters SHIFT.
- Requester protocol: a requester that sees gnt high must drop req or present a new word on the next cycle. A req asserted outside the window waits.
- Timing for a grant in cycle n (from IDLE):
  - n+1: LOAD.
  - n+2 .. n+WIDTH: SHIFT, with q = d[WIDTH-1] down to d[1].
  - n+WIDTH+1: LAST, with q = d[0] and done = 1.
  - Latency from grant to the first valid bit is 2 cycles. A word occupies WIDTH valid cycles.
- Back-to-back words: a grant during the final SHIFT cycle makes the next word's MSB valid in the cycle right after LAST. bit_valid stays continuously high across the word boundary.
- busy is high in LOAD, SHIFT and LAST. src holds its value while idle.

Test Plan:
- WIDTH = 4. After reset, check all outputs are 0. Then req0 = 1 with d0 = 4'b1011 for one cycle:
  - gnt0 pulses in that cycle.
  - s sequence from the grant cycle is 0,0,1,1,1,0.
  - With a behavioural shift-register model, q = 1,0,1,1 over the 4 bit_valid cycles, with done on the 4th and src = 0.
- req0 and req1 both held high from reset, d0 = 4'b1100, d1 = 4'b0011:
  - Grants alternate 0,1,0,1.
  - The serial stream is 1100 0011 1100 0011 with bit_valid never dropping between words.
- req1 rises during the second SHIFT cycle of a requester-0 word:
  - No gnt1 until the final SHIFT cycle (cnt == 2).
  - Its word follows with zero gap and src = 1.
- Assert rst asynchronously mid-SHIFT:
  - All outputs clear immediately and no done is issued.
  - After release, req1 alone with d1 = 4'b0110 serialises as 0,1,1,0.
- WIDTH = 2 instance, req0 held with d0 alternating 2'b10, 2'b01:
  - SHIFT lasts one cycle and a grant occurs in every SHIFT cycle.
  - Stream is 1,0,0,1,... with continuous bit_valid.
- req0 high with the grant window closed (LOAD or LAST):
  - gnt0 stays 0.
  - The grant occurs at the next window only.
